gpio_pad_ctrl: RTL
==================

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 Parameter NUM_BIDIR, 8, number of bidirectional pad channels (1..32).
REQ-002 Parameter NUM_INPUT, 4, number of input-only pad channels (1..32).
REQ-003 Parameter SYNC_STAGES, 2, input synchroniser depth (>=2).
REQ-004 Parameter SETTLE_CYCLES, 16, post-reset cycles with pads held safe (>=1).
REQ-005 clk  input  1  single block clock.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 req_valid  input  1  register access request.
REQ-008 req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  4  word address.
REQ-011 req_wdata  input  32  write data; bit i maps to channel i.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  read data; 0 for writes.
REQ-014 bidir_in  input  NUM_BIDIR  Y from the bidirectional pads (asynchronous).
REQ-015 input_in  input  NUM_INPUT  Y from the input pads (asynchronous).
REQ-016 bidir_out, bidir_oe, bidir_ie, bidir_cs, bidir_sl, bidir_pu, bidir_pd  output  NUM_BIDIR each  A/OE/IE/CS/SL/PU/PD to the pads.
REQ-017 input_pu, input_pd  output  NUM_INPUT each  PU/PD to the input pads.
REQ-018 edge_irq  output  1  OR of all unmasked sticky edge flags.

Function
REQ-019 The startup FSM SHALL have states SETTLE and ACTIVE; reset enters SETTLE; SETTLE counts SETTLE_CYCLES clocks, then moves to ACTIVE; ACTIVE persists until reset.
REQ-020 In SETTLE: req_ready=0; bidir_oe, bidir_ie, bidir_pu and bidir_pd SHALL be forced to 0.
REQ-021 In ACTIVE: req_ready=1; each pad output SHALL equal its config register, subject to REQ-027.
REQ-022 Register map: 0 OUT, 1 OE, 2 IE, 3 PU, 4 PD, 5 CS, 6 SL (bidir config, RW); 7 IPU, 8 IPD (input-pad pulls, RW); 9 BIN (RO, synchronised bidir_in); 10 IIN (RO, synchronised input_in); 11 EDGE (sticky flags, W1C); 12 MASK (RW); 13 CTRL (bit0 LOCK, bits[2:1] EDGE_MODE: 0 rise, 1 fall, 2 both, 3 none).
REQ-023 Bits at or above the channel count SHALL read 0 and ignore writes; unmapped addresses SHALL read 0 and ignore writes.
REQ-024 An accepted request SHALL produce rsp_valid exactly one cycle later; a write takes effect on the acceptance edge; a read returns the value from before that edge.
REQ-025 Each bidir_in and input_in bit SHALL pass through a SYNC_STAGES flop chain; a pad change SHALL appear in BIN/IIN SYNC_STAGES cycles after the first sampling edge.
REQ-026 EDGE[i] SHALL set one cycle after synchronised bidir_in[i] shows the edge selected by EDGE_MODE. Edge detection SHALL run in both SETTLE and ACTIVE. If a set and a W1C hit the same bit in the same cycle, set SHALL win.
REQ-027 If PU[i] and PD[i] are both 1, bidir_pu[i] SHALL be 0 (PD wins); IPU/IPD SHALL follow the same rule.
REQ-028 edge_irq SHALL be registered: edge_irq = |(EDGE & MASK), one cycle after the flag or mask changes.
REQ-029 Once LOCK=1, writes to addresses 0-8 and 13 SHALL be ignored until reset, but still SHALL return rsp_valid; EDGE W1C and MASK writes SHALL remain allowed.

Reset
REQ-030 On rst_n low, all registers SHALL clear asynchronously to: OUT/OE/PU/PD/CS/SL/IPU/IPD/EDGE/MASK/CTRL=0, IE=all-ones, synchronisers=0, FSM=SETTLE, counter=0, rsp_valid=0, rsp_rdata=0, edge_irq=0, req_ready=0, and every pad output=0.
REQ-031 Reset asserted during any access SHALL drop the pending response; no rsp_valid SHALL follow.

Verification
REQ-032 Release reset, hold req_valid=1 -> req_ready stays 0 for 16 cycles, then goes 1; bidir_ie goes from 0x00 to 0xFF on that same cycle.
REQ-033 Write OE=0xA5, then read addr 1 -> bidir_oe=0xA5 after the write edge; rsp_rdata=0x000000A5 one cycle after the read is accepted.
REQ-034 Write PU=0x03 and PD=0x01 -> bidir_pu=0x02 and bidir_pd=0x01.
REQ-035 With MASK=0x01, drive bidir_in[0] 0->1 -> BIN[0]=1 after 2 cycles, EDGE=0x01 after 3 cycles, edge_irq=1 after 4 cycles; W1C 0x01 on the same cycle as a new edge -> EDGE stays 0x01.
REQ-036 Write CTRL=0x1, then OUT=0xFF -> bidir_out unchanged, rsp_valid still pulses; then pulse rst_n low mid-read -> no rsp_valid, all outputs 0, FSM back in SETTLE.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: register-mapped pad control with startup settle window, input synchronisers and edge flags.
module gpio_pad_ctrl #(
  parameter int NUM_BIDIR     = 8,
  parameter int NUM_INPUT     = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [3:0]           req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  input  logic [NUM_BIDIR-1:0] bidir_in,
  input  logic [NUM_INPUT-1:0] input_in,
  output logic [NUM_BIDIR-1:0] bidir_out,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  output logic [NUM_INPUT-1:0] input_pu,
  output logic [NUM_INPUT-1:0] input_pd,
  output logic                 edge_irq
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  typedef enum logic {SETTLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic active;
  logic [NUM_BIDIR-1:0] out_r, oe_r, ie_r, pu_r, pd_r, cs_r, sl_r, edge_r, mask_r, prev_r, det, w1c, bin, wd_b;
  logic [NUM_INPUT-1:0] ipu_r, ipd_r, iin, wd_i;
  logic [SYNC_STAGES-1:0][NUM_BIDIR-1:0] bsync;
  logic [SYNC_STAGES-1:0][NUM_INPUT-1:0] isync;
  logic [2:0] ctrl_r;
  logic [31:0] rd;
  logic accept, wr, wr_cfg, unused_wdata;
  assign accept = req_valid & req_ready;
  assign wr = accept & req_write;
  assign wr_cfg = wr & ~ctrl_r[0];
  assign wd_b = req_wdata[NUM_BIDIR-1:0];
  assign wd_i = req_wdata[NUM_INPUT-1:0];
  assign unused_wdata = ^req_wdata;
  assign bin = bsync[SYNC_STAGES-1];
  assign iin = isync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (state == SETTLE) cnt <= cnt + 1'b1;
  end
  always_comb begin
    state_nxt = (state == SETTLE && cnt == CW'(SETTLE_CYCLES - 1)) ? ACTIVE : state;
  end
  always_comb begin
    active = state == ACTIVE;
    req_ready = active;
  end
  // Locked configuration registers stay frozen; EDGE clear and MASK remain writable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= '0;
      oe_r <= '0;
      ie_r <= '1;
      pu_r <= '0;
      pd_r <= '0;
      cs_r <= '0;
      sl_r <= '0;
      ipu_r <= '0;
      ipd_r <= '0;
      mask_r <= '0;
      ctrl_r <= '0;
    end else begin
      if (wr_cfg && req_addr == 4'd0) out_r <= wd_b;
      if (wr_cfg && req_addr == 4'd1) oe_r <= wd_b;
      if (wr_cfg && req_addr == 4'd2) ie_r <= wd_b;
      if (wr_cfg && req_addr == 4'd3) pu_r <= wd_b;
      if (wr_cfg && req_addr == 4'd4) pd_r <= wd_b;
      if (wr_cfg && req_addr == 4'd5) cs_r <= wd_b;
      if (wr_cfg && req_addr == 4'd6) sl_r <= wd_b;
      if (wr_cfg && req_addr == 4'd7) ipu_r <= wd_i;
      if (wr_cfg && req_addr == 4'd8) ipd_r <= wd_i;
      if (wr && req_addr == 4'd12) mask_r <= wd_b;
      if (wr_cfg && req_addr == 4'd13) ctrl_r <= req_wdata[2:0];
    end
  end
  always_comb begin
    det = ctrl_r[2:1] == 2'd0 ? bin & ~prev_r :
          ctrl_r[2:1] == 2'd1 ? ~bin & prev_r :
          ctrl_r[2:1] == 2'd2 ? bin ^ prev_r : '0;
    w1c = (wr && req_addr == 4'd11) ? wd_b : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsync <= '0;
      isync <= '0;
      prev_r <= '0;
      edge_r <= '0;
      edge_irq <= 1'b0;
    end else begin
      bsync <= {bsync[SYNC_STAGES-2:0], bidir_in};
      isync <= {isync[SYNC_STAGES-2:0], input_in};
      prev_r <= bin;
      edge_r <= (edge_r & ~w1c) | det;
      edge_irq <= |(edge_r & mask_r);
    end
  end
  always_comb begin
    rd = '0;
    case (req_addr)
      4'd0:  rd = 32'(out_r);
      4'd1:  rd = 32'(oe_r);
      4'd2:  rd = 32'(ie_r);
      4'd3:  rd = 32'(pu_r);
      4'd4:  rd = 32'(pd_r);
      4'd5:  rd = 32'(cs_r);
      4'd6:  rd = 32'(sl_r);
      4'd7:  rd = 32'(ipu_r);
      4'd8:  rd = 32'(ipd_r);
      4'd9:  rd = 32'(bin);
      4'd10: rd = 32'(iin);
      4'd11: rd = 32'(edge_r);
      4'd12: rd = 32'(mask_r);
      4'd13: rd = 32'(ctrl_r);
      default: rd = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_rdata <= (accept && !req_write) ? rd : '0;
    end
  end
  assign bidir_out = out_r;
  assign bidir_cs = cs_r;
  assign bidir_sl = sl_r;
  assign bidir_oe = active ? oe_r : '0;
  assign bidir_ie = active ? ie_r : '0;
  assign bidir_pu = active ? pu_r & ~pd_r : '0;
  assign bidir_pd = active ? pd_r : '0;
  assign input_pu = ipu_r & ~ipd_r;
  assign input_pd = ipd_r;
endmodule
